decode_stage: RTL
=================

Name: decode_stage

Overview:
- Instruction decode / issue stage for the RV32 core; sits between fetch and the ALU.
- Accepts fetched instructions over a valid/ready handshake and splits them into opcode, funct3 and funct7.
- Reads the internal 32x32 register file, generates the sign-extended immediate, and presents one registered issue packet whose fields feed the ALU inputs directly.
- Handles load-use stall, branch/jump flush and writeback-to-read bypass.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- NREGS, 32, architectural registers; x0 hardwired to zero.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents instruction
- if_ready  out  1  stage accepts instruction this cycle
- if_instr  in  32  instruction word
- if_pc  in  32  PC of if_instr
- flush  in  1  taken branch/jump from execute (ALU branch_taken)
- wb_we  in  1  writeback enable
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback value
- ex_ready  in  1  execute accepts packet
- ex_valid  out  1  issue packet valid
- ex_opcode  out  7  instr[6:0]
- ex_funct3  out  3  instr[14:12]
- ex_funct7  out  7  instr[31:25]
- ex_operand1  out  32  rs1 value
- ex_operand2  out  32  rs2 value or shamt
- ex_immediate  out  32  decoded immediate
- ex_pc  out  32  instruction PC
- ex_rd  out  5  destination register
- ex_reg_write  out  1  instruction writes rd
- ex_mem_read  out  1  load
- ex_mem_write  out  1  store

Behaviour:
- Reset (async, reset_n=0): every ex_* output is 0, and all registers x1..x31 are 0. if_ready is combinational and follows the equation below.
- Accept condition: if_ready = !flush & !hazard & (!ex_valid | ex_ready).
- Transfer: a transfer occurs when if_valid & if_ready. On the next edge the packet register loads the decoded instruction and ex_valid=1. Latency is 1 cycle.
- Drain: if ex_valid & ex_ready and no transfer occurs, ex_valid=0 next edge. While ex_valid & !ex_ready, the packet holds stable.
- Flush: has highest priority. ex_valid=0 next edge, no instruction is accepted, and all other packet fields are don't-care. Register file writes still occur during flush.
- Immediate, selected by opcode:
  - I (0010011, 0000011, 1110011): sext(instr[31:20])
  - S (0100011): sext({instr[31:25], instr[11:7]})
  - B (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - U (0110111, 0010111): {instr[31:12], 12'b0}
  - J (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - any other opcode: 0
- Operand2:
  - opcode 0010011 with funct3 001/101: zero-extended instr[24:20] (shamt)
  - opcodes 0110011, 1100011, 0100011: rs2 value
  - otherwise: 0
- Operand1: rs1 value for opcodes 0110011, 0010011, 1100011, 0000011, 0100011, 1110011; otherwise 0.
- Control decode:
  - ex_reg_write=1 for 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, and for 1110011 with funct3=001. It is forced to 0 when rd=0.
  - ex_mem_read=1 only for 0000011.
  - ex_mem_write=1 only for 0100011.
  - Unknown opcodes issue with all three control bits at 0.
- Register file:
  - Write on the clock edge when wb_we & wb_rd!=0; writes to x0 are ignored and x0 always reads 0.
  - Bypass: a read of register r in the same cycle as wb_we & wb_rd==r (r!=0) returns wb_data.
- Load-use hazard: asserted when all of the following hold:
  - ex_valid & ex_mem_read & ex_rd!=0 & if_valid, and
  - (uses_rs1 & instr[19:15]==ex_rd) | (uses_rs2 & instr[24:20]==ex_rd), where uses_rs1/uses_rs2 follow the operand1/operand2 rs-value opcode lists above.
  - While hazard is asserted, if_ready=0. If ex_ready=1, the load drains and ex_valid=0 next cycle, which is exactly one bubble; the hazard then clears.
- Simultaneous events:
  - flush together with hazard: flush wins.
  - flush with a wb write: the write is performed.
  - reset mid-operation: the packet is discarded and the register file is cleared.

Test Plan:
- Reset, then if_valid=1 with 0x00500093 (addi x1,x0,5) and pc=0x100: ex_valid=1 next cycle, opcode=0x13, operand1=0, immediate=5, rd=1, reg_write=1, if_ready=1 throughout.
- Immediates:
  - sw x2,-4(x1) (0xFE20AE23) gives immediate=0xFFFFFFFC, mem_write=1, operand2=x2 value.
  - beq with offset -8 gives 0xFFFFFFF8.
  - lui 0x12345 gives 0x12345000.
  - slli x3,x3,4 gives operand2=4.
- Bypass: wb_we=1, wb_rd=5, wb_data=0xDEADBEEF in the same cycle as add x6,x5,x0 is accepted: ex_operand1=0xDEADBEEF. A write to x0 followed by a read of x0 returns 0.
- Load-use: lw x7,0(x1) issued, then add x8,x7,x7 presented: if_ready=0 for one cycle, one bubble (ex_valid=0), then the add issues. With add x8,x9,x9 instead, no stall occurs.
- Backpressure then flush: hold ex_ready=0 for 3 cycles and the packet stays stable with if_ready=0. Assert flush for 1 cycle: ex_valid=0 next cycle, the presented instruction is not accepted, and it is accepted on the following cycle.
- Async reset mid-stream: drop reset_n between edges: ex_valid=0 immediately and x5 reads 0 afterwards.

Source files
------------

// File: rtl/decode_stage.sv
// RV32 decode/issue stage: takes fetched instructions over valid/ready, reads the
// 32x32 register file with writeback bypass, and registers one ALU issue packet.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [31:0]     if_pc,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic [XLEN-1:0] ex_operand1,
    output logic [XLEN-1:0] ex_operand2,
    output logic [XLEN-1:0] ex_immediate,
    output logic [31:0]     ex_pc,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [XLEN-1:0] regs [NREGS];

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1, rs2, rd;
    logic            uses_rs1, uses_rs2;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] imm, operand1, operand2;
    logic            reg_write, mem_read, mem_write;
    logic            hazard, transfer;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign funct7 = if_instr[31:25];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rd     = if_instr[11:7];

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        imm       = '0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (opcode)
            OP_REG: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                reg_write = 1'b1;
            end
            OP_IMM: begin
                uses_rs1  = 1'b1;
                imm       = {{20{if_instr[31]}}, if_instr[31:20]};
                reg_write = 1'b1;
            end
            OP_LOAD: begin
                uses_rs1  = 1'b1;
                imm       = {{20{if_instr[31]}}, if_instr[31:20]};
                reg_write = 1'b1;
                mem_read  = 1'b1;
            end
            OP_SYSTEM: begin
                uses_rs1  = 1'b1;
                imm       = {{20{if_instr[31]}}, if_instr[31:20]};
                reg_write = (funct3 == 3'b001);
            end
            OP_STORE: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                imm       = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                mem_write = 1'b1;
            end
            OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm      = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                            if_instr[30:25], if_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                imm       = {if_instr[31:12], 12'b0};
                reg_write = 1'b1;
            end
            OP_JAL: begin
                imm       = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                             if_instr[20], if_instr[30:21], 1'b0};
                reg_write = 1'b1;
            end
            default: ;
        endcase
        if (rd == 5'd0) reg_write = 1'b0;
    end

    // Writeback is forwarded so an instruction decoded alongside its producer's write sees the new value.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0) rs1_val = (wb_we && wb_rd == rs1) ? wb_data : regs[rs1];
        if (rs2 != 5'd0) rs2_val = (wb_we && wb_rd == rs2) ? wb_data : regs[rs2];
    end

    always_comb begin
        operand1 = uses_rs1 ? rs1_val : '0;
        operand2 = '0;
        if (opcode == OP_IMM && (funct3 == 3'b001 || funct3 == 3'b101))
            operand2 = {{(XLEN-5){1'b0}}, if_instr[24:20]};
        else if (uses_rs2)
            operand2 = rs2_val;
    end

    assign hazard = ex_valid && ex_mem_read && (ex_rd != 5'd0) && if_valid &&
                    ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));

    assign if_ready = !flush && !hazard && (!ex_valid || ex_ready);
    assign transfer = if_valid && if_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid     <= 1'b0;
            ex_opcode    <= '0;
            ex_funct3    <= '0;
            ex_funct7    <= '0;
            ex_operand1  <= '0;
            ex_operand2  <= '0;
            ex_immediate <= '0;
            ex_pc        <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (transfer) begin
            ex_valid     <= 1'b1;
            ex_opcode    <= opcode;
            ex_funct3    <= funct3;
            ex_funct7    <= funct7;
            ex_operand1  <= operand1;
            ex_operand2  <= operand2;
            ex_immediate <= imm;
            ex_pc        <= if_pc;
            ex_rd        <= rd;
            ex_reg_write <= reg_write;
            ex_mem_read  <= mem_read;
            ex_mem_write <= mem_write;
        end else if (ex_valid && ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    // NOTE: the register file is cleared by reset, so it maps to flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_we && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

endmodule
